shift_request_queue: RTL and testbench
======================================

# shift_request_queue

Buffered issue stage directly upstream of the 32-bit barrel shifter. Accepts shift requests (data word, shift amount, fill bit) over a valid/ready handshake and holds them in a small FIFO. Presents the FIFO head to an internal `BarrelShifter #(DATAWIDTH)` instance, then registers the shifted result into an output stage with its own valid/ready handshake. Bursty producers can therefore issue shifts without stalling on a slow consumer.

## Interface
- DATAWIDTH, 32, data word width; power of 2, ≥ 4.
- DEPTH, 4, FIFO entries; power of 2, ≥ 2.
- muxNum (localparam), $clog2(DATAWIDTH), shift amount width.
- Clock  input  1  rising-edge clock for all state.
- ResetN  input  1  reset, synchronous, active-low.
- InValid  input  1  request present.
- InReady  output  1  queue can accept a request this cycle.
- InData  input  DATAWIDTH  word to shift.
- InAmount  input  muxNum  left-shift amount.
- InShiftIn  input  1  fill bit for vacated LSBs.
- OutValid  output  1  OutData holds a completed result.
- OutReady  input  1  consumer takes the result this cycle.
- OutData  output  DATAWIDTH  registered shift result.
- Count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH; excludes the output register.

## Operation
- Push: on a rising edge where InValid && InReady, write {InData, InAmount, InShiftIn} at the write pointer. Write pointer increments modulo DEPTH.
- InReady = (Count != DEPTH). InReady is combinational from state only and never depends on OutReady, so there is no pass-through when full.
- Head entry drives the BarrelShifter.
- Shifter result: (In << amt) with the low amt bits equal to ShiftIn. amt = 0 returns In unchanged.
- Output register load condition: FIFO non-empty && (!OutValid || OutReady). On load:
  - OutData ← shifter result, OutValid ← 1.
  - Read pointer increments modulo DEPTH.
- If OutValid && OutReady and the FIFO is empty, OutValid ← 0. OutData holds its last value.
- Count: +1 on push only, −1 on load only, unchanged when both occur on the same edge.
- Total capacity is DEPTH + 1 requests: DEPTH in the FIFO plus one in the output register.
- Requests complete strictly in arrival order. No request is dropped or duplicated.
- X on InData is legal when InValid = 0 and must not propagate into state.

## Timing
- Reset, when ResetN is sampled low on a rising edge:
  - Count = 0, both pointers = 0, OutValid = 0, OutData = 0, so InReady = 1.
  - All queued requests, including one held in the output register, are discarded.
- Latency: a request accepted at edge N into an empty queue with an empty output register gives OutValid = 1 after edge N+1.
- Throughput: one request per cycle sustained when OutReady = 1.
- Stability: while OutValid && !OutReady, OutData and OutValid hold unchanged.
- Pointer wrap: write and read pointers wrap from DEPTH−1 to 0. Full and empty are distinguished by Count, not by pointer equality.
- Reset asserted mid-burst takes priority over a simultaneous push or pop on that edge.

## Configuration
- SHIFT_QUEUE_STATS_EN
  - Defined: adds output port DoneCount [15:0].
    - Increments on every edge with OutValid && OutReady.
    - Saturates at 16'hFFFF.
    - Cleared to 0 by reset.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
Use DATAWIDTH = 32 and DEPTH = 4 unless stated.
- Reset: hold ResetN low for 2 edges with InValid = 1 → OutValid = 0, OutData = 0, Count = 0, InReady = 1, nothing enqueued.
- Single request, OutReady = 1: InData = 32'h0000_00F0, InAmount = 4, InShiftIn = 1 → OutData = 32'h0000_0F0F, OutValid high exactly one edge after accept.
- Fill: OutReady = 0, push 6 back-to-back requests → first 5 accepted, Count = 4, InReady = 0 on the 6th. Raise OutReady → results drain in push order, one per cycle.
- Concurrent push/pop at Count = 2 with OutValid = 1 and OutReady = 1 → Count stays 2, order preserved across pointer wrap.
- Boundaries, each checked against the reference model (In << amt) | (ShiftIn ? 2**amt − 1 : 0):
  - InData = 1, InAmount = 31, InShiftIn = 1 → 32'hFFFF_FFFF.
  - InData = 32'hA5A5_A5A5, InAmount = 0, InShiftIn = 1 → 32'hA5A5_A5A5.
  - 200 random requests with random OutReady, all results matching the model.
- Reset mid-operation with 3 queued requests, then 1 new push → only the new request appears. With SHIFT_QUEUE_STATS_EN, DoneCount restarts at 0 and reads 1 after that output.

Source files
------------

// File: rtl/shift_request_queue.sv
// Buffered issue stage feeding a barrel shifter: FIFO of shift requests,
// registered result stage. Optional SHIFT_QUEUE_STATS_EN adds DoneCount.
//
// Ports:
//   Clock, ResetN        clock, synchronous active-low reset
//   InValid/InReady      request handshake
//   InData/InAmount      word to shift, left-shift amount
//   InShiftIn            fill bit for vacated LSBs
//   OutValid/OutReady    result handshake
//   OutData              registered shift result
//   Count                FIFO occupancy (excludes output register)
//   DoneCount            completed results (SHIFT_QUEUE_STATS_EN only)

module BarrelShifter #(
  parameter int DATAWIDTH = 32,
  localparam int muxNum = $clog2(DATAWIDTH)
) (
  input  logic [DATAWIDTH-1:0] In,
  input  logic [muxNum-1:0]    Amount,
  input  logic                 ShiftIn,
  output logic [DATAWIDTH-1:0] Out
);

  logic [muxNum:0][DATAWIDTH-1:0] stg;

  assign stg[0] = In;

  // Log-depth stages; stage i shifts by 2**i and fills with ShiftIn.
  for (genvar i = 0; i < muxNum; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stg[i+1] = Amount[i]
      ? {stg[i][DATAWIDTH-1-S:0], {S{ShiftIn}}}
      : stg[i];
  end

  assign Out = stg[muxNum];

endmodule

module shift_request_queue #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 4,
  localparam int muxNum = $clog2(DATAWIDTH)
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATAWIDTH-1:0]     InData,
  input  logic [muxNum-1:0]        InAmount,
  input  logic                     InShiftIn,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATAWIDTH-1:0]     OutData,
  output logic [$clog2(DEPTH):0]   Count
`ifdef SHIFT_QUEUE_STATS_EN
  ,
  output logic [15:0]              DoneCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATAWIDTH + muxNum + 1;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovalid_q, ovalid_d;
  logic [DATAWIDTH-1:0] odata_q, odata_d;

  logic                 push;
  logic                 load;
  logic [EW-1:0]        head;
  logic [DATAWIDTH-1:0] head_data;
  logic [muxNum-1:0]    head_amt;
  logic                 head_fill;
  logic [DATAWIDTH-1:0] sh_res;

  assign InReady = (count_q != CW'(DEPTH));
  assign push    = InValid && InReady;
  assign load    = (count_q != '0) && (!ovalid_q || OutReady);

  assign head = mem_q[rptr_q];
  assign {head_data, head_amt, head_fill} = head;

  BarrelShifter #(.DATAWIDTH(DATAWIDTH)) u_shift (
    .In      (head_data),
    .Amount  (head_amt),
    .ShiftIn (head_fill),
    .Out     (sh_res)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    // Pointers wrap naturally since DEPTH is a power of 2.
    if (push) wptr_d = wptr_q + AW'(1);
    if (load) begin
      rptr_d   = rptr_q + AW'(1);
      ovalid_d = 1'b1;
      odata_d  = sh_res;
    end else if (ovalid_q && OutReady) begin
      ovalid_d = 1'b0;
    end
    unique case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  // Storage needs no reset: only entries below Count are ever read.
  always_ff @(posedge Clock) begin
    if (ResetN && push) begin
      mem_q[wptr_q] <= {InData, InAmount, InShiftIn};
    end
  end

  assign OutValid = ovalid_q;
  assign OutData  = odata_q;
  assign Count    = count_q;

`ifdef SHIFT_QUEUE_STATS_EN
  logic [15:0] done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (ovalid_q && OutReady && (done_q != 16'hFFFF)) begin
      done_d = done_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) done_q <= '0;
    else         done_q <= done_d;
  end

  assign DoneCount = done_q;
`endif

endmodule

// File: tb/tb_shift_request_queue.sv
// Directed and randomized checks of shift_request_queue
// (DATAWIDTH = 32, DEPTH = 4).

module tb_shift_request_queue;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        InValid;
  logic        InReady;
  logic [31:0] InData;
  logic [4:0]  InAmount;
  logic        InShiftIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [2:0]  Count;
`ifdef SHIFT_QUEUE_STATS_EN
  logic [15:0] DoneCount;
`endif

  int vectors = 0;
  int miscompares = 0;

  shift_request_queue #(.DATAWIDTH(32), .DEPTH(4)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .InValid   (InValid),
    .InReady   (InReady),
    .InData    (InData),
    .InAmount  (InAmount),
    .InShiftIn (InShiftIn),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutData   (OutData),
    .Count     (Count)
`ifdef SHIFT_QUEUE_STATS_EN
    ,
    .DoneCount (DoneCount)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] model(
    input logic [31:0] d, input logic [4:0] a, input logic f);
    logic [31:0] m;
    m = (32'd1 << a) - 32'd1;
    return (d << a) | (f ? m : 32'd0);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [4:0] a, input logic f);
    InValid   = v;
    InData    = d;
    InAmount  = a;
    InShiftIn = f;
  endtask

  // Single request into an idle queue with OutReady high.
  task automatic one(input string tag, input logic [31:0] d,
                     input logic [4:0] a, input logic f,
                     input logic [31:0] exp);
    OutReady = 1'b1;
    drive(1'b1, d, a, f);
    chk({tag, "_rdy"}, 32'(InReady), 32'd1);
    tick();
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    chk({tag, "_ov0"}, 32'(OutValid), 32'd0);
    tick();
    chk({tag, "_ov1"}, 32'(OutValid), 32'd1);
    chk({tag, "_data"}, OutData, exp);
    tick();
    chk({tag, "_ovdone"}, 32'(OutValid), 32'd0);
    chk({tag, "_hold"}, OutData, exp);
  endtask

  logic [31:0] dq [6];
  logic [31:0] expq [$];
  logic [31:0] rd, e;
  logic [4:0]  ra;
  logic        rf;
  int          sent, got, cyc;

  initial begin
    ResetN   = 1'b0;
    OutReady = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1);
    tick();
    tick();
    chk("rst_ov", 32'(OutValid), 32'd0);
    chk("rst_od", OutData, 32'd0);
    chk("rst_cnt", 32'(Count), 32'd0);
    chk("rst_rdy", 32'(InReady), 32'd1);
    ResetN = 1'b1;
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    tick();
    chk("rst_empty", 32'(Count), 32'd0);
    chk("rst_ov2", 32'(OutValid), 32'd0);

    one("single", 32'h0000_00F0, 5'd4, 1'b1, 32'h0000_0F0F);

    // Fill: 4 in FIFO + 1 in output register, 6th refused.
    OutReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dq[i] = 32'h0101_0000 * (i + 1) + 32'(i);
      drive(1'b1, dq[i], 5'(i), i[0]);
      chk($sformatf("fill_rdy%0d", i), 32'(InReady),
          (i < 5) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    chk("fill_cnt", 32'(Count), 32'd4);
    chk("fill_rdy", 32'(InReady), 32'd0);
    chk("fill_ov", 32'(OutValid), 32'd1);
    chk("fill_d0", OutData, model(dq[0], 5'd0, 1'b0));
    tick();
    chk("fill_stable", OutData, model(dq[0], 5'd0, 1'b0));
    OutReady = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("drain_v%0d", k), 32'(OutValid), 32'd1);
      chk($sformatf("drain_d%0d", k), OutData,
          model(dq[k], 5'(k), k[0]));
    end
    tick();
    chk("drain_ov0", 32'(OutValid), 32'd0);
    chk("drain_cnt", 32'(Count), 32'd0);

    // Concurrent push/pop at Count = 2 across pointer wrap.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dq[i] = 32'h1234_5670 + 32'(i);
      drive(1'b1, dq[i], 5'(i + 8), 1'b1);
      tick();
    end
    chk("cc_cnt", 32'(Count), 32'd2);
    chk("cc_ov", 32'(OutValid), 32'd1);
    OutReady = 1'b1;
    for (int i = 3; i < 5; i++) begin
      dq[i] = 32'h8765_4320 + 32'(i);
      drive(1'b1, dq[i], 5'(i + 8), 1'b0);
      tick();
      chk($sformatf("cc_cnt%0d", i), 32'(Count), 32'd2);
      chk($sformatf("cc_d%0d", i), OutData,
          model(dq[i-2], 5'(i + 6), (i - 2) < 3));
    end
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    for (int i = 3; i < 5; i++) begin
      tick();
      chk($sformatf("cc_tail%0d", i), OutData,
          model(dq[i], 5'(i + 8), 1'b0));
    end
    tick();
    chk("cc_empty", 32'(OutValid), 32'd0);

    one("amt31", 32'd1, 5'd31, 1'b1, 32'hFFFF_FFFF);
    one("amt0", 32'hA5A5_A5A5, 5'd0, 1'b1, 32'hA5A5_A5A5);

    // Random traffic against the reference model.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 200 && cyc < 5000) begin
      rd = $urandom;
      ra = 5'($urandom_range(31));
      rf = 1'($urandom_range(1));
      drive((sent < 200) && ($urandom_range(1) == 1), rd, ra, rf);
      OutReady = ($urandom_range(3) != 0);
      if (OutValid && OutReady) begin
        e = expq.pop_front();
        chk($sformatf("rand%0d", got), OutData, e);
        got++;
      end
      if (InValid && InReady) begin
        expq.push_back(model(rd, ra, rf));
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rand_done", 32'(got), 32'd200);
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    OutReady = 1'b1;
    tick();
    tick();

    // Reset with 3 requests queued; reset beats a concurrent push.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hCAFE_0000 + 32'(i), 5'd1, 1'b0);
      tick();
    end
    chk("mid_cnt", 32'(Count), 32'd2);
    ResetN = 1'b0;
    drive(1'b1, 32'hBAD0_BAD0, 5'd2, 1'b1);
    OutReady = 1'b1;
    tick();
    ResetN = 1'b1;
    chk("mid_rst_cnt", 32'(Count), 32'd0);
    chk("mid_rst_ov", 32'(OutValid), 32'd0);
`ifdef SHIFT_QUEUE_STATS_EN
    chk("mid_rst_done", 32'(DoneCount), 32'd0);
`endif
    drive(1'b1, 32'h0000_0003, 5'd8, 1'b0);
    tick();
    drive(1'b0, 32'hx, 5'hx, 1'bx);
    tick();
    chk("mid_new_ov", 32'(OutValid), 32'd1);
    chk("mid_new_d", OutData, 32'h0000_0300);
    tick();
    chk("mid_only", 32'(OutValid), 32'd0);
    chk("mid_cnt0", 32'(Count), 32'd0);
`ifdef SHIFT_QUEUE_STATS_EN
    chk("mid_done1", 32'(DoneCount), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
